dmem_port_scheduler: RTL and testbench

Sequential owner of the single data-cache port, shared between the load reservation station and the committed store buffer. Each cycle with the port free it picks one requester and issues one word-aligned request to the data cache. It then holds the port until `dmem_resp` and routes the response back: load data with its ROB tag, or a store-done pulse. Stores win by default; an optional starvation guard bounds how long a pending load can be held off.

---
 rtl/dmem_port_scheduler_pkg.sv | 23 ++
 rtl/dmem_port_scheduler_if.sv | 55 +++++
 rtl/dmem_port_scheduler.sv | 130 +++++++++++++
 tb/tb_dmem_port_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_scheduler_pkg.sv
// Shared types and constants for the data-cache port scheduler.
// Optional starvation guard is enabled by defining DMEM_PORT_STARVE_GUARD_EN.
package dmem_sched_pkg;

    localparam logic [1:0] ST_IDLE             = 2'd0;
    localparam logic [1:0] ST_WAIT_LOAD        = 2'd1;
    localparam logic [1:0] ST_WAIT_LOAD_KILLED = 2'd2;
    localparam logic [1:0] ST_WAIT_STORE       = 2'd3;

    typedef enum logic [1:0] {
        IDLE             = ST_IDLE,
        WAIT_LOAD        = ST_WAIT_LOAD,
        WAIT_LOAD_KILLED = ST_WAIT_LOAD_KILLED,
        WAIT_STORE       = ST_WAIT_STORE
    } dmem_sched_state_t;

    localparam logic [31:0] DMEM_ALIGN_MASK = 32'hfffffffc;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & DMEM_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/dmem_port_scheduler_if.sv
// Bundle of load RS, store buffer, response and data-cache signals around the scheduler.
// The scheduler uses the slave modport; the surrounding pipeline/cache uses master.
interface dmem_port_scheduler_if #(
    parameter int TAG_W = 5
) ();

    logic             flush;

    logic             load_req;
    logic [31:0]      load_addr;
    logic [3:0]       load_rmask;
    logic [TAG_W-1:0] load_tag;
    logic             load_grant;

    logic             store_req;
    logic [31:0]      store_addr;
    logic [3:0]       store_wmask;
    logic [31:0]      store_wdata;
    logic             store_grant;
    logic             store_done;

    logic             load_resp_valid;
    logic [31:0]      load_resp_rdata;
    logic [TAG_W-1:0] load_resp_tag;

    logic [31:0]      dmem_addr;
    logic [3:0]       dmem_rmask;
    logic [3:0]       dmem_wmask;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata;
    logic             dmem_resp;

    modport slave (
        input  flush,
        input  load_req, load_addr, load_rmask, load_tag,
        output load_grant,
        input  store_req, store_addr, store_wmask, store_wdata,
        output store_grant, store_done,
        output load_resp_valid, load_resp_rdata, load_resp_tag,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport master (
        output flush,
        output load_req, load_addr, load_rmask, load_tag,
        input  load_grant,
        output store_req, store_addr, store_wmask, store_wdata,
        input  store_grant, store_done,
        input  load_resp_valid, load_resp_rdata, load_resp_tag,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/dmem_port_scheduler.sv
// Owner of the single data-cache port: arbitrates load RS vs store buffer, one request in flight.
// Define DMEM_PORT_STARVE_GUARD_EN to bound how many store grants a waiting load tolerates.
module dmem_port_scheduler
    import dmem_sched_pkg::*;
#(
    parameter int TAG_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_port_scheduler_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dmem_port_scheduler: STARVE_LIMIT must be in 1..15");
    end

    dmem_sched_state_t r_state;
    dmem_sched_state_t w_next_state;
    logic [TAG_W-1:0]  r_tag;
    logic              w_sel_load;
    logic              w_sel_store;
    logic              w_load_eligible;
    logic              w_starve_full;

`ifdef DMEM_PORT_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] r_starve;
`endif

    always_comb begin
        w_next_state        = r_state;
        w_sel_load          = 1'b0;
        w_sel_store         = 1'b0;
        w_load_eligible     = bus.load_req && !bus.flush;
`ifdef DMEM_PORT_STARVE_GUARD_EN
        w_starve_full       = (r_starve == CNT_W'(STARVE_LIMIT));
`else
        w_starve_full       = 1'b0;
`endif
        bus.load_grant      = 1'b0;
        bus.store_grant     = 1'b0;
        bus.store_done      = 1'b0;
        bus.load_resp_valid = 1'b0;
        bus.load_resp_rdata = '0;
        bus.load_resp_tag   = '0;
        bus.dmem_addr       = '0;
        bus.dmem_rmask      = '0;
        bus.dmem_wmask      = '0;
        bus.dmem_wdata      = '0;

        // Outputs are held quiet while reset is asserted, even mid-cycle.
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_load_eligible && w_starve_full) begin
                        w_sel_load = 1'b1;
                    end else if (bus.store_req) begin
                        w_sel_store = 1'b1;
                    end else if (w_load_eligible) begin
                        w_sel_load = 1'b1;
                    end

                    if (w_sel_store) begin
                        bus.store_grant = 1'b1;
                        bus.dmem_addr   = word_align(bus.store_addr);
                        bus.dmem_wmask  = bus.store_wmask;
                        bus.dmem_wdata  = bus.store_wdata;
                        w_next_state    = WAIT_STORE;
                    end else if (w_sel_load) begin
                        bus.load_grant  = 1'b1;
                        bus.dmem_addr   = word_align(bus.load_addr);
                        bus.dmem_rmask  = bus.load_rmask;
                        w_next_state    = WAIT_LOAD;
                    end
                end
                WAIT_STORE: begin
                    if (bus.dmem_resp) begin
                        bus.store_done = 1'b1;
                        w_next_state   = IDLE;
                    end
                end
                WAIT_LOAD: begin
                    if (bus.dmem_resp) begin
                        if (!bus.flush) begin
                            bus.load_resp_valid = 1'b1;
                            bus.load_resp_rdata = bus.dmem_rdata;
                            bus.load_resp_tag   = r_tag;
                        end
                        w_next_state = IDLE;
                    end else if (bus.flush) begin
                        w_next_state = WAIT_LOAD_KILLED;
                    end
                end
                WAIT_LOAD_KILLED: begin
                    if (bus.dmem_resp) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tag    <= '0;
`ifdef DMEM_PORT_STARVE_GUARD_EN
            r_starve <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_sel_load) begin
                r_tag <= bus.load_tag;
            end
`ifdef DMEM_PORT_STARVE_GUARD_EN
            // Saturating count of store grants issued past a waiting load.
            if (r_state == IDLE) begin
                if (w_sel_load || !bus.load_req) begin
                    r_starve <= '0;
                end else if (w_sel_store && !w_starve_full) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Self-checking bench for dmem_port_scheduler: directed vector table, starvation sequence,
// and randomized traffic against a transaction-level reference model.
module tb_dmem_port_scheduler;

    localparam int TAG_W        = 5;
    localparam int STARVE_LIMIT = 4;

`ifdef DMEM_PORT_STARVE_GUARD_EN
    localparam bit    GUARD     = 1'b1;
    localparam string GUARD_EXP = "SSSSLSSSSL";
`else
    localparam bit    GUARD     = 1'b0;
    localparam string GUARD_EXP = "SSSSSSSSSS";
`endif

    typedef struct packed {
        logic             lg;
        logic             sg;
        logic             sd;
        logic             lv;
        logic [31:0]      rdata;
        logic [TAG_W-1:0] tag;
        logic [31:0]      addr;
        logic [3:0]       rmask;
        logic [3:0]       wmask;
        logic [31:0]      wdata;
    } out_t;

    typedef struct {
        bit               rst;
        bit               flush;
        bit               lreq;
        logic [31:0]      laddr;
        logic [3:0]       lrmask;
        logic [TAG_W-1:0] ltag;
        bit               sreq;
        logic [31:0]      saddr;
        logic [3:0]       swmask;
        logic [31:0]      swdata;
        bit               resp;
        logic [31:0]      rdata;
        out_t             exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    out_t g_got;

    // Reference model: one outstanding transaction described by kind and a kill flag.
    bit               m_busy    = 1'b0;
    bit               m_is_load = 1'b0;
    bit               m_killed  = 1'b0;
    logic [TAG_W-1:0] m_tag     = '0;
    int               m_starve  = 0;

    always #5 clk = ~clk;

    dmem_port_scheduler_if #(.TAG_W(TAG_W)) bus ();

    dmem_port_scheduler #(
        .TAG_W        (TAG_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic out_t dut_out();
        out_t o;
        o.lg    = bus.load_grant;
        o.sg    = bus.store_grant;
        o.sd    = bus.store_done;
        o.lv    = bus.load_resp_valid;
        o.rdata = bus.load_resp_rdata;
        o.tag   = bus.load_resp_tag;
        o.addr  = bus.dmem_addr;
        o.rmask = bus.dmem_rmask;
        o.wmask = bus.dmem_wmask;
        o.wdata = bus.dmem_wdata;
        return o;
    endfunction

    function automatic out_t model_eval();
        out_t e = '0;
        bit   full;
        bit   want_load;
        if (rst) return e;
        full      = GUARD && (m_starve == STARVE_LIMIT);
        want_load = bus.load_req && !bus.flush;
        if (!m_busy) begin
            if (want_load && (full || !bus.store_req)) begin
                e.lg    = 1'b1;
                e.addr  = {bus.load_addr[31:2], 2'b00};
                e.rmask = bus.load_rmask;
            end else if (bus.store_req) begin
                e.sg    = 1'b1;
                e.addr  = {bus.store_addr[31:2], 2'b00};
                e.wmask = bus.store_wmask;
                e.wdata = bus.store_wdata;
            end
        end else if (bus.dmem_resp) begin
            if (!m_is_load) begin
                e.sd = 1'b1;
            end else if (!m_killed && !bus.flush) begin
                e.lv    = 1'b1;
                e.rdata = bus.dmem_rdata;
                e.tag   = m_tag;
            end
        end
        return e;
    endfunction

    task automatic model_commit(input out_t e);
        if (rst) begin
            m_busy   = 1'b0;
            m_killed = 1'b0;
            m_starve = 0;
            return;
        end
        if (!m_busy) begin
            if (e.lg) begin
                m_busy    = 1'b1;
                m_is_load = 1'b1;
                m_killed  = 1'b0;
                m_tag     = bus.load_tag;
                m_starve  = 0;
            end else if (e.sg) begin
                m_busy    = 1'b1;
                m_is_load = 1'b0;
                m_killed  = 1'b0;
                if (bus.load_req && m_starve < STARVE_LIMIT) m_starve++;
            end
            if (!bus.load_req) m_starve = 0;
        end else if (bus.dmem_resp) begin
            m_busy = 1'b0;
        end else if (m_is_load && bus.flush) begin
            m_killed = 1'b1;
        end
    endtask

    task automatic check(input string name, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
        n_tests++;
        if (got.rmask != 4'h0 && got.wmask != 4'h0) begin
            n_fail++;
            $display("FAIL %s_masks: got rmask %h wmask %h expected one of them zero", name, got.rmask, got.wmask);
        end
    endtask

    // Inputs are driven 1 time unit after the edge; sample mid-cycle, then advance the model.
    task automatic step(input string name, input bit use_row, input out_t row_exp);
        out_t exp;
        #4;
        g_got = dut_out();
        exp   = model_eval();
        check(name, g_got, use_row ? row_exp : exp);
        @(posedge clk);
        model_commit(exp);
        #1;
    endtask

    task automatic drive_idle();
        bus.flush       = 1'b0;
        bus.load_req    = 1'b0;
        bus.load_addr   = '0;
        bus.load_rmask  = '0;
        bus.load_tag    = '0;
        bus.store_req   = 1'b0;
        bus.store_addr  = '0;
        bus.store_wmask = '0;
        bus.store_wdata = '0;
        bus.dmem_resp   = 1'b0;
        bus.dmem_rdata  = '0;
    endtask

    function automatic out_t o_none();
        return '0;
    endfunction
    function automatic out_t o_ld(input logic [31:0] a, input logic [3:0] m);
        out_t o = '0;
        o.lg = 1'b1; o.addr = a; o.rmask = m;
        return o;
    endfunction
    function automatic out_t o_st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        out_t o = '0;
        o.sg = 1'b1; o.addr = a; o.wmask = m; o.wdata = d;
        return o;
    endfunction
    function automatic out_t o_sd();
        out_t o = '0;
        o.sd = 1'b1;
        return o;
    endfunction
    function automatic out_t o_lv(input logic [31:0] d, input logic [TAG_W-1:0] t);
        out_t o = '0;
        o.lv = 1'b1; o.rdata = d; o.tag = t;
        return o;
    endfunction

    function automatic vec_t v(input bit r, input bit f,
                               input bit lq, input logic [31:0] la, input logic [3:0] lm, input logic [TAG_W-1:0] lt,
                               input bit sq, input logic [31:0] sa, input logic [3:0] sm, input logic [31:0] sd,
                               input bit rs, input logic [31:0] rd, input out_t e);
        vec_t x;
        x.rst = r; x.flush = f;
        x.lreq = lq; x.laddr = la; x.lrmask = lm; x.ltag = lt;
        x.sreq = sq; x.saddr = sa; x.swmask = sm; x.swdata = sd;
        x.resp = rs; x.rdata = rd; x.exp = e;
        return x;
    endfunction

    vec_t  vecs[$];
    string order;

    initial begin
        drive_idle();

        // rst flush lreq laddr lrmask ltag | sreq saddr wmask wdata | resp rdata | expected
        vecs.push_back(v(1,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 1,32'h1003,4'hf,5'd7, 0,32'h0,4'h0,32'h0, 0,32'h0, o_ld(32'h1000,4'hf)));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 1,32'hdeadbeef, o_lv(32'hdeadbeef,5'd7)));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 1,32'h40,4'hf,5'd3, 1,32'h20,4'h3,32'h1234, 0,32'h0, o_st(32'h20,4'h3,32'h1234)));
        vecs.push_back(v(0,0, 1,32'h40,4'hf,5'd3, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 1,32'h40,4'hf,5'd3, 0,32'h0,4'h0,32'h0, 1,32'h0, o_sd()));
        vecs.push_back(v(0,0, 1,32'h40,4'hf,5'd3, 0,32'h0,4'h0,32'h0, 0,32'h0, o_ld(32'h40,4'hf)));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 1,32'h55, o_lv(32'h55,5'd3)));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 1,32'h106,4'h3,5'd9, 0,32'h0,4'h0,32'h0, 0,32'h0, o_ld(32'h104,4'h3)));
        vecs.push_back(v(0,1, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 1,32'hb,4'hf,32'hcafe, 1,32'h11, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 1,32'hb,4'hf,32'hcafe, 0,32'h0, o_st(32'h8,4'hf,32'hcafe)));
        vecs.push_back(v(0,1, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,1, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 1,32'h0, o_sd()));
        vecs.push_back(v(0,1, 1,32'h200,4'hf,5'd1, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 1,32'h200,4'hf,5'd1, 0,32'h0,4'h0,32'h0, 0,32'h0, o_ld(32'h200,4'hf)));
        vecs.push_back(v(1,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 1,32'hffffffff, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));
        vecs.push_back(v(0,0, 1,32'h300,4'hf,5'd4, 0,32'h0,4'h0,32'h0, 0,32'h0, o_ld(32'h300,4'hf)));
        vecs.push_back(v(0,1, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 1,32'h77, o_none()));
        vecs.push_back(v(0,0, 0,32'h0,4'h0,5'd0, 0,32'h0,4'h0,32'h0, 0,32'h0, o_none()));

        foreach (vecs[i]) begin
            rst             = vecs[i].rst;
            bus.flush       = vecs[i].flush;
            bus.load_req    = vecs[i].lreq;
            bus.load_addr   = vecs[i].laddr;
            bus.load_rmask  = vecs[i].lrmask;
            bus.load_tag    = vecs[i].ltag;
            bus.store_req   = vecs[i].sreq;
            bus.store_addr  = vecs[i].saddr;
            bus.store_wmask = vecs[i].swmask;
            bus.store_wdata = vecs[i].swdata;
            bus.dmem_resp   = vecs[i].resp;
            bus.dmem_rdata  = vecs[i].rdata;
            step($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
        end

        // Both requesters held: grant order shows the starvation guard, or strict store priority.
        drive_idle();
        rst = 1'b0;
        step("guard_pre", 1'b0, '0);
        order = "";
        for (int c = 0; c < 200 && order.len() < 10; c++) begin
            bus.load_req    = 1'b1;
            bus.load_addr   = 32'h500;
            bus.load_rmask  = 4'hf;
            bus.load_tag    = 5'd2;
            bus.store_req   = 1'b1;
            bus.store_addr  = 32'h600 + 32'(c);
            bus.store_wmask = 4'h1;
            bus.store_wdata = 32'(c);
            bus.dmem_resp   = m_busy;
            bus.dmem_rdata  = 32'h1000 + 32'(c);
            step("guard", 1'b0, '0);
            if (g_got.sg) order = {order, "S"};
            else if (g_got.lg) order = {order, "L"};
        end
        n_tests++;
        if (order != GUARD_EXP) begin
            n_fail++;
            $display("FAIL grant_order: got %s expected %s", order, GUARD_EXP);
        end

        drive_idle();
        step("drain", 1'b0, '0);
        while (m_busy) begin
            bus.dmem_resp = 1'b1;
            step("drain", 1'b0, '0);
        end

        for (int c = 0; c < 600; c++) begin
            rst             = ($urandom_range(0, 99) < 2);
            bus.flush       = ($urandom_range(0, 99) < 15);
            bus.load_req    = ($urandom_range(0, 1) == 0);
            bus.load_addr   = $urandom;
            bus.load_rmask  = 4'($urandom);
            bus.load_tag    = TAG_W'($urandom);
            bus.store_req   = ($urandom_range(0, 9) < 4);
            bus.store_addr  = $urandom;
            bus.store_wmask = 4'($urandom);
            bus.store_wdata = $urandom;
            bus.dmem_rdata  = $urandom;
            if (m_busy)
                bus.dmem_resp = ($urandom_range(0, 2) == 0);
            else
                bus.dmem_resp = !bus.load_req && !bus.store_req && ($urandom_range(0, 9) == 0);
            step("rand", 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
